// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and length helpers for the AXI Stream packet generator.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;

    function automatic int unsigned beat_count(input int unsigned len, input int unsigned bytes);
        return (len + bytes - 1) / bytes;
    endfunction

    function automatic int unsigned rem_bytes(input int unsigned len, input int unsigned bytes);
        return len % bytes;
    endfunction

endpackage

// File: rtl/axis_keep_mask.sv
// Maps a last-beat byte remainder to a tkeep mask; remainder 0 means a full beat.
module axis_keep_mask
    import axis_pkt_gen_pkg::*;
#(
    parameter  int unsigned NUM_BYTES = BYTES,
    localparam int unsigned REM_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic [REM_W-1:0]     i_rem,
    output logic [NUM_BYTES-1:0] o_keep
);

    always_comb begin
        o_keep = '0;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            o_keep[i] = (i_rem == '0) || (i < int'(i_rem));
        end
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI Stream packet generator: fixed-length patterned packets with optional gap and abort.
// Optional feature: AXIS_PKT_GEN_STALL_CNT_EN adds a saturating backpressure counter port.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                    m_axis_aclk,
    input  logic                    m_axis_resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [CNT_WIDTH-1:0]    pkt_count,
    input  logic [CNT_WIDTH-1:0]    gap,
    input  logic [7:0]              seed,
    output logic                    busy,
    output logic                    done,
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
    output logic [31:0]             stall_cnt,
`endif
    output logic                    m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [2:0]              m_axis_tid,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic [0:0]              m_axis_tdest,
    input  logic                    m_axis_tready
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned REM_W = (NB > 1) ? $clog2(NB) : 1;

    state_t                 r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_len, r_beat;
    logic [CNT_WIDTH-1:0]   r_count, r_gap, r_pkt, r_gap_cnt;
    logic [7:0]             r_seed;
    logic                   r_abort, r_busy, r_done;
    logic                   r_tvalid, r_tlast;
    logic [DATA_WIDTH-1:0]  r_tdata;
    logic [NB-1:0]          r_tkeep;
    logic [2:0]             r_tid;
    logic [TUSER_WIDTH-1:0] r_tuser;

    logic                   w_hs, w_abort_any, w_last_pkt;
    logic                   w_load, w_drop, w_beat_last;
    logic [CNT_WIDTH-1:0]   w_ld_pkt;
    logic [LEN_WIDTH-1:0]   w_ld_beat, w_cur_len, w_nbeats;
    logic [7:0]             w_cur_seed, w_base;
    logic [REM_W-1:0]       w_rem;
    logic [NB-1:0]          w_last_keep, w_keep;
    logic [DATA_WIDTH-1:0]  w_data;

    assign w_hs        = r_tvalid && m_axis_tready;
    assign w_abort_any = r_abort || abort;
    assign w_last_pkt  = (r_pkt == r_count - CNT_WIDTH'(1));

    // In IDLE the first beat is built straight from the start-time inputs.
    assign w_cur_len  = (r_state == IDLE) ? pkt_len : r_len;
    assign w_cur_seed = (r_state == IDLE) ? seed    : r_seed;
    assign w_nbeats   = LEN_WIDTH'(beat_count(32'(w_cur_len), NB));
    assign w_rem      = REM_W'(rem_bytes(32'(w_cur_len), NB));

    axis_keep_mask #(.NUM_BYTES(NB)) u_keep_mask (
        .i_rem  (w_rem),
        .o_keep (w_last_keep)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_ld_pkt    = r_pkt;
        w_ld_beat   = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (pkt_len == '0 || pkt_count == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SEND;
                        w_load      = 1'b1;
                        w_ld_pkt    = '0;
                    end
                end
            end
            SEND: begin
                if (w_hs) begin
                    if (!r_tlast) begin
                        w_load    = 1'b1;
                        w_ld_beat = r_beat + LEN_WIDTH'(1);
                    end else if (w_last_pkt || w_abort_any) begin
                        w_state_nxt = DONE;
                        w_drop      = 1'b1;
                    end else if (r_gap != '0) begin
                        w_state_nxt = GAP;
                        w_drop      = 1'b1;
                    end else begin
                        w_load   = 1'b1;
                        w_ld_pkt = r_pkt + CNT_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (w_abort_any) begin
                    w_state_nxt = DONE;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt = SEND;
                    w_load      = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Byte k of packet p is seed + p + k; lanes past the packet end stay zero.
    always_comb begin
        w_beat_last = (w_ld_beat == w_nbeats - LEN_WIDTH'(1));
        w_keep      = w_beat_last ? w_last_keep : '1;
        w_base      = w_cur_seed + 8'(w_ld_pkt) + 8'(w_ld_beat * NB);
        w_data      = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (w_keep[i]) w_data[i*8 +: 8] = w_base + 8'(i);
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_resetn) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_gap     <= '0;
            r_seed    <= '0;
            r_pkt     <= '0;
            r_beat    <= '0;
            r_gap_cnt <= '0;
            r_abort   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tkeep   <= '0;
            r_tlast   <= 1'b0;
            r_tid     <= '0;
            r_tuser   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // busy drops in the same cycle done pulses.
            r_busy  <= (w_state_nxt == SEND) || (w_state_nxt == GAP);
            r_done  <= (w_state_nxt == DONE);
            if (r_state == IDLE && start) begin
                r_len   <= pkt_len;
                r_count <= pkt_count;
                r_gap   <= gap;
                r_seed  <= seed;
                r_abort <= 1'b0;
            end else if ((r_state == SEND || r_state == GAP) && abort) begin
                r_abort <= 1'b1;
            end
            if (w_load) begin
                r_pkt <= w_ld_pkt;
            end else if (r_state == SEND && w_hs && r_tlast) begin
                r_pkt <= r_pkt + CNT_WIDTH'(1);
            end
            if (r_state == SEND) begin
                r_gap_cnt <= r_gap - CNT_WIDTH'(1);
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt - CNT_WIDTH'(1);
            end
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_data;
                r_tkeep  <= w_keep;
                r_tlast  <= w_beat_last;
                r_tid    <= 3'(w_ld_pkt);
                r_tuser  <= TUSER_WIDTH'(w_ld_beat == '0);
                r_beat   <= w_ld_beat;
            end else if (w_drop) begin
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
                r_tkeep  <= '0;
                r_tlast  <= 1'b0;
                r_tid    <= '0;
                r_tuser  <= '0;
            end
        end
    end

`ifdef AXIS_PKT_GEN_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_resetn) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_stall_cnt <= '0;
        end else if (r_tvalid && !m_axis_tready && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign busy          = r_busy;
    assign done          = r_done;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tid    = r_tid;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tdest  = 1'b0;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen (DATA_WIDTH=32) with hand-computed beat values.
module tb_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [15:0] pkt_count = '0;
    logic [15:0] gap = '0;
    logic [7:0]  seed = '0;
    logic        tready = 1'b1;
    logic        busy, done, tvalid, tlast;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic [2:0]  tid;
    logic [0:0]  tuser, tdest;
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_pkt_gen #(
        .DATA_WIDTH  (32),
        .TUSER_WIDTH (1),
        .LEN_WIDTH   (16),
        .CNT_WIDTH   (16)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_resetn (rstn),
        .start         (start),
        .abort         (abort),
        .pkt_len       (pkt_len),
        .pkt_count     (pkt_count),
        .gap           (gap),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tid    (tid),
        .m_axis_tuser  (tuser),
        .m_axis_tdest  (tdest),
        .m_axis_tready (tready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic [2:0] id, input logic u);
        check({tag, ".tvalid"}, 32'(tvalid), 32'd1);
        check({tag, ".tdata"},  tdata, d);
        check({tag, ".tkeep"},  32'(tkeep), 32'(k));
        check({tag, ".tlast"},  32'(tlast), 32'(l));
        check({tag, ".tid"},    32'(tid), 32'(id));
        check({tag, ".tuser"},  32'(tuser), 32'(u));
    endtask

    task automatic status(input string tag, input logic v, input logic dn, input logic bz);
        check({tag, ".tvalid"}, 32'(tvalid), 32'(v));
        check({tag, ".done"},   32'(done), 32'(dn));
        check({tag, ".busy"},   32'(busy), 32'(bz));
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".ctl"},  {26'd0, tvalid, tlast, busy, done, tuser, tdest}, 32'd0);
        check({tag, ".data"}, tdata, 32'd0);
        check({tag, ".keep"}, {25'd0, tid, tkeep}, 32'd0);
    endtask

    // Start is raised for one cycle; returns at the cycle the first beat is visible.
    task automatic launch(input logic [15:0] len, input logic [15:0] cnt,
                          input logic [15:0] g, input logic [7:0] sd);
        pkt_len = len;
        pkt_count = cnt;
        gap = g;
        seed = sd;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        all_zero("reset");
        rstn = 1'b1;
        step();

        // Two full beats, single packet.
        launch(16'd8, 16'd1, 16'd0, 8'h10);
        beat("s1b0", 32'h13121110, 4'hF, 1'b0, 3'd0, 1'b1);
        check("s1.busy", 32'(busy), 32'd1);
        step();
        beat("s1b1", 32'h17161514, 4'hF, 1'b1, 3'd0, 1'b0);
        step();
        status("s1.end", 1'b0, 1'b1, 1'b0);
        step();
        status("s1.idle", 1'b0, 1'b0, 1'b0);

        // Partial last beat, back-to-back packets.
        launch(16'd5, 16'd2, 16'd0, 8'h00);
        beat("s2p0b0", 32'h03020100, 4'hF, 1'b0, 3'd0, 1'b1);
        step();
        beat("s2p0b1", 32'h00000004, 4'h1, 1'b1, 3'd0, 1'b0);
        step();
        beat("s2p1b0", 32'h04030201, 4'hF, 1'b0, 3'd1, 1'b1);
        step();
        beat("s2p1b1", 32'h00000005, 4'h1, 1'b1, 3'd1, 1'b0);
        step();
        status("s2.end", 1'b0, 1'b1, 1'b0);
        step();

        // Backpressure on the first beat for three cycles.
        tready = 1'b0;
        launch(16'd8, 16'd1, 16'd0, 8'h10);
        for (int i = 0; i < 4; i++) begin
            beat($sformatf("s3hold%0d", i), 32'h13121110, 4'hF, 1'b0, 3'd0, 1'b1);
            if (i == 3) tready = 1'b1;
            if (i < 3) step();
        end
        step();
        beat("s3b1", 32'h17161514, 4'hF, 1'b1, 3'd0, 1'b0);
        step();
        status("s3.end", 1'b0, 1'b1, 1'b0);
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
        check("s3.stall_cnt", stall_cnt, 32'd3);
`endif
        step();

        // Gap of four idle cycles; a start during the gap must be ignored.
        launch(16'd4, 16'd2, 16'd4, 8'h20);
        beat("s4p0", 32'h23222120, 4'hF, 1'b1, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            start = (i == 1);
            if (i == 1) begin
                seed = 8'hAA;
                pkt_len = 16'd1;
            end
            status($sformatf("s4gap%0d", i), 1'b0, 1'b0, 1'b1);
        end
        step();
        start = 1'b0;
        beat("s4p1", 32'h24232221, 4'hF, 1'b1, 3'd1, 1'b1);
        step();
        status("s4.end", 1'b0, 1'b1, 1'b0);
        step();

        // Abort while packet 0 is in flight: it completes, nothing follows.
        launch(16'd8, 16'd3, 16'd0, 8'h40);
        beat("s5b0", 32'h43424140, 4'hF, 1'b0, 3'd0, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        beat("s5b1", 32'h47464544, 4'hF, 1'b1, 3'd0, 1'b0);
        step();
        status("s5.end", 1'b0, 1'b1, 1'b0);
        step();
        status("s5.idle", 1'b0, 1'b0, 1'b0);

        // Reset mid-packet, then degenerate starts.
        launch(16'd8, 16'd4, 16'd0, 8'h00);
        beat("s6b0", 32'h03020100, 4'hF, 1'b0, 3'd0, 1'b1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        all_zero("s6.rst");
        step();
        status("s6.noresume", 1'b0, 1'b0, 1'b0);
        launch(16'd0, 16'd1, 16'd0, 8'h00);
        status("s6.len0", 1'b0, 1'b1, 1'b0);
        step();
        status("s6.len0.after", 1'b0, 1'b0, 1'b0);
        launch(16'd4, 16'd0, 16'd0, 8'h00);
        status("s6.cnt0", 1'b0, 1'b1, 1'b0);
        step();
        status("s6.cnt0.after", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
